// File: rtl/pc_sched_pkg.sv
// Shared constants for the PC scheduler: hold levels, redirect priorities and bus widths.
package pc_sched_pkg;

  localparam int BUS_HOLD_CODE = 3;
  localparam int BUS_ADDR_MEM  = 32;

  localparam logic [BUS_HOLD_CODE-1:0] HOLD_CODE_NONE = 3'd0;
  localparam logic [BUS_HOLD_CODE-1:0] HOLD_CODE_PC   = 3'd1;
  localparam logic [BUS_HOLD_CODE-1:0] HOLD_CODE_IF   = 3'd2;
  localparam logic [BUS_HOLD_CODE-1:0] HOLD_CODE_ID   = 3'd3;
  localparam logic [BUS_HOLD_CODE-1:0] HOLD_CODE_EX   = 3'd4;
  localparam logic [BUS_HOLD_CODE-1:0] HOLD_CODE_MEM  = 3'd5;

  // Lower value wins arbitration.
  localparam logic [1:0] PRI_TRAP = 2'd0;
  localparam logic [1:0] PRI_MRET = 2'd1;
  localparam logic [1:0] PRI_BR   = 2'd2;
  localparam logic [1:0] PRI_NONE = 2'd3;

  typedef enum logic {
    ST_IDLE,
    ST_PEND
  } sched_state_e;

  function automatic logic [BUS_HOLD_CODE-1:0] holdMax(
    input logic [BUS_HOLD_CODE-1:0] a,
    input logic [BUS_HOLD_CODE-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pc_sched_if.sv
// Bundle between hazard/exception logic and the PC scheduler.
interface pc_sched_if
  import pc_sched_pkg::*;
#(
  parameter int ADDR_W = BUS_ADDR_MEM
);

  logic                     if_wait;
  logic                     lu_hazard;
  logic                     div_busy;
  logic                     mem_wait;
  logic                     trap_en;
  logic [ADDR_W-1:0]        trap_vec;
  logic                     mret_en;
  logic [ADDR_W-1:0]        mepc;
  logic                     br_en;
  logic [ADDR_W-1:0]        br_to;
  logic [BUS_HOLD_CODE-1:0] hold_code;
  logic                     jmp_en;
  logic [ADDR_W-1:0]        jmp_to;
  logic                     flush_fe;
  logic                     pend;
  logic                     hang_err;

  modport master (
    output if_wait, lu_hazard, div_busy, mem_wait,
    output trap_en, trap_vec, mret_en, mepc, br_en, br_to,
    input  hold_code, jmp_en, jmp_to, flush_fe, pend, hang_err
  );

  modport slave (
    input  if_wait, lu_hazard, div_busy, mem_wait,
    input  trap_en, trap_vec, mret_en, mepc, br_en, br_to,
    output hold_code, jmp_en, jmp_to, flush_fe, pend, hang_err
  );

endinterface

// File: rtl/pc_sched_redir_arb.sv
// Fixed-priority redirect select: trap over mret over branch.
module redir_arb
  import pc_sched_pkg::*;
#(
  parameter int ADDR_W = BUS_ADDR_MEM
) (
  input  logic              trapEn_i,
  input  logic [ADDR_W-1:0] trapVec_i,
  input  logic              mretEn_i,
  input  logic [ADDR_W-1:0] mepc_i,
  input  logic              brEn_i,
  input  logic [ADDR_W-1:0] brTo_i,
  output logic              winEn_o,
  output logic [ADDR_W-1:0] winAddr_o,
  output logic [1:0]        winPri_o
);

  always_comb begin
    winEn_o   = trapEn_i | mretEn_i | brEn_i;
    winAddr_o = '0;
    winPri_o  = PRI_NONE;
    if (trapEn_i) begin
      winAddr_o = trapVec_i;
      winPri_o  = PRI_TRAP;
    end else if (mretEn_i) begin
      winAddr_o = mepc_i;
      winPri_o  = PRI_MRET;
    end else if (brEn_i) begin
      winAddr_o = brTo_i;
      winPri_o  = PRI_BR;
    end
  end

endmodule

// File: rtl/pc_sched.sv
// PC scheduler: merges stall levels, issues redirects, buffers redirects that arrive while the PC is held.
module pc_sched
  import pc_sched_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int HANG_LIMIT = 1024,
  parameter int CNT_W      = 11
) (
  input  logic       clk,
  input  logic       rst,
  pc_sched_if.slave  bus
);

  logic [BUS_HOLD_CODE-1:0] holdRaw;
  logic                     held;
  logic                     winEn;
  logic [ADDR_W-1:0]        winAddr;
  logic [1:0]               winPri;
  logic                     override;
  logic                     jmpEn;
  logic [ADDR_W-1:0]        jmpTo;

  sched_state_e      state_q,    state_d;
  logic [ADDR_W-1:0] pendAddr_q, pendAddr_d;
  logic [1:0]        pendPri_q,  pendPri_d;
  logic [CNT_W-1:0]  holdCnt_q,  holdCnt_d;
  logic              hangErr_q,  hangErr_d;

  always_comb begin
    holdRaw = HOLD_CODE_NONE;
    if (bus.if_wait)   holdRaw = holdMax(holdRaw, HOLD_CODE_PC);
    if (bus.lu_hazard) holdRaw = holdMax(holdRaw, HOLD_CODE_ID);
    if (bus.div_busy)  holdRaw = holdMax(holdRaw, HOLD_CODE_EX);
    if (bus.mem_wait)  holdRaw = holdMax(holdRaw, HOLD_CODE_MEM);
  end

  assign held = (holdRaw >= HOLD_CODE_PC);

  redir_arb #(.ADDR_W(ADDR_W)) u_arb (
    .trapEn_i  (bus.trap_en),
    .trapVec_i (bus.trap_vec),
    .mretEn_i  (bus.mret_en),
    .mepc_i    (bus.mepc),
    .brEn_i    (bus.br_en),
    .brTo_i    (bus.br_to),
    .winEn_o   (winEn),
    .winAddr_o (winAddr),
    .winPri_o  (winPri)
  );

  assign override = winEn && (winPri < pendPri_q);

  // Redirects go out combinationally; only one that meets a held PC is buffered.
  always_comb begin
    state_d    = state_q;
    pendAddr_d = pendAddr_q;
    pendPri_d  = pendPri_q;
    jmpEn      = 1'b0;
    jmpTo      = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (winEn && !held) begin
          jmpEn = 1'b1;
          jmpTo = winAddr;
        end else if (winEn) begin
          pendAddr_d = winAddr;
          pendPri_d  = winPri;
          state_d    = ST_PEND;
        end
      end
      ST_PEND: begin
        if (held) begin
          if (override) begin
            pendAddr_d = winAddr;
            pendPri_d  = winPri;
          end
        end else begin
          jmpEn     = 1'b1;
          jmpTo     = override ? winAddr : pendAddr_q;
          pendPri_d = PRI_NONE;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    if (!held)
      holdCnt_d = '0;
    else if (holdCnt_q == CNT_W'(HANG_LIMIT))
      holdCnt_d = holdCnt_q;
    else
      holdCnt_d = holdCnt_q + 1'b1;
    hangErr_d = hangErr_q | (holdCnt_d == CNT_W'(HANG_LIMIT));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pendAddr_q <= '0;
      pendPri_q  <= PRI_NONE;
      holdCnt_q  <= '0;
      hangErr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pendAddr_q <= pendAddr_d;
      pendPri_q  <= pendPri_d;
      holdCnt_q  <= holdCnt_d;
      hangErr_q  <= hangErr_d;
    end
  end

  // Reset masks the combinational paths so nothing leaks out while rst is high.
  assign bus.hold_code = rst ? HOLD_CODE_NONE : holdRaw;
  assign bus.jmp_en    = jmpEn & ~rst;
  assign bus.flush_fe  = jmpEn & ~rst;
  assign bus.jmp_to    = rst ? '0 : jmpTo;
  assign bus.pend      = (state_q == ST_PEND) & ~rst;
  assign bus.hang_err  = hangErr_q;

endmodule

// File: tb/tb_pc_sched.sv
// Scoreboard bench for pc_sched: stimulus pushes model expectations, a negedge monitor compares.
module tb_pc_sched;

  localparam int ADDR_W     = 32;
  localparam int HANG_LIMIT = 1024;
  localparam int CNT_W      = 11;

  typedef struct packed {
    logic              rst;
    logic              ifWait;
    logic              luHazard;
    logic              divBusy;
    logic              memWait;
    logic              trapEn;
    logic [ADDR_W-1:0] trapVec;
    logic              mretEn;
    logic [ADDR_W-1:0] mepc;
    logic              brEn;
    logic [ADDR_W-1:0] brTo;
  } stim_t;

  typedef struct packed {
    logic [2:0]        hold;
    logic              jmpEn;
    logic [ADDR_W-1:0] jmpTo;
    logic              flush;
    logic              pend;
    logic              hangErr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   testsRun    = 0;
  int   testsFailed = 0;
  int   cycle       = 0;
  exp_t expQ[$];

  logic              mPendValid = 1'b0;
  logic [ADDR_W-1:0] mPendAddr  = '0;
  int                mPendPri   = 3;
  int                mRun       = 0;
  logic              mHang      = 1'b0;

  pc_sched_if #(.ADDR_W(ADDR_W)) bus ();

  pc_sched #(
    .ADDR_W     (ADDR_W),
    .HANG_LIMIT (HANG_LIMIT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference: stall level is the deepest requested stage; redirects obey trap > mret > br.
  task automatic modelCycle(input stim_t s, output exp_t e);
    int                lv;
    int                wPri;
    logic [ADDR_W-1:0] wAddr;
    logic              held;
    logic              win;
    logic              beats;
    int                levels[4];
    logic              reqs[4];
    levels = '{1, 3, 4, 5};
    reqs   = '{s.ifWait, s.luHazard, s.divBusy, s.memWait};
    lv = 0;
    for (int i = 0; i < 4; i++) if (reqs[i] && levels[i] > lv) lv = levels[i];
    held  = (lv != 0);
    wPri  = 3;
    wAddr = '0;
    if (s.brEn)   begin wPri = 2; wAddr = s.brTo;    end
    if (s.mretEn) begin wPri = 1; wAddr = s.mepc;    end
    if (s.trapEn) begin wPri = 0; wAddr = s.trapVec; end
    win = (wPri != 3);
    e = '0;
    if (s.rst) begin
      mPendValid = 1'b0;
      mPendPri   = 3;
      mRun       = 0;
      mHang      = 1'b0;
      return;
    end
    e.hold    = 3'(lv);
    e.pend    = mPendValid;
    e.hangErr = mHang;
    beats = win && (!mPendValid || wPri < mPendPri);
    if (!held && (mPendValid || win)) begin
      e.jmpEn    = 1'b1;
      e.jmpTo    = beats ? wAddr : mPendAddr;
      mPendValid = 1'b0;
      mPendPri   = 3;
    end else if (held && beats) begin
      mPendValid = 1'b1;
      mPendAddr  = wAddr;
      mPendPri   = wPri;
    end
    e.flush = e.jmpEn;
    mRun = held ? ((mRun < HANG_LIMIT) ? mRun + 1 : HANG_LIMIT) : 0;
    if (mRun == HANG_LIMIT) mHang = 1'b1;
  endtask

  task automatic applyStimulus(input stim_t s);
    exp_t e;
    @(posedge clk);
    #1;
    rst           = s.rst;
    bus.if_wait   = s.ifWait;
    bus.lu_hazard = s.luHazard;
    bus.div_busy  = s.divBusy;
    bus.mem_wait  = s.memWait;
    bus.trap_en   = s.trapEn;
    bus.trap_vec  = s.trapVec;
    bus.mret_en   = s.mretEn;
    bus.mepc      = s.mepc;
    bus.br_en     = s.brEn;
    bus.br_to     = s.brTo;
    modelCycle(s, e);
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    exp_t got;
    got.hold    = bus.hold_code;
    got.jmpEn   = bus.jmp_en;
    got.jmpTo   = bus.jmp_to;
    got.flush   = bus.flush_fe;
    got.pend    = bus.pend;
    got.hangErr = bus.hang_err;
    testsRun++;
    if (got !== e) begin
      testsFailed++;
      $display("[TB] FAIL cycle%0d outputs: got hold=%0d jmp=%b to=%h flush=%b pend=%b hang=%b, want hold=%0d jmp=%b to=%h flush=%b pend=%b hang=%b",
               cycle, got.hold, got.jmpEn, got.jmpTo, got.flush, got.pend, got.hangErr,
               e.hold, e.jmpEn, e.jmpTo, e.flush, e.pend, e.hangErr);
    end
  endtask

  always @(negedge clk) begin
    cycle++;
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  initial begin
    stim_t s;
    bus.if_wait = 1'b0; bus.lu_hazard = 1'b0; bus.div_busy = 1'b0; bus.mem_wait = 1'b0;
    bus.trap_en = 1'b0; bus.trap_vec = '0; bus.mret_en = 1'b0; bus.mepc = '0;
    bus.br_en = 1'b0; bus.br_to = '0;

    s = '0; s.rst = 1'b1; s.ifWait = 1'b1; s.brEn = 1'b1; s.brTo = 32'h44;
    applyStimulus(s);
    applyStimulus(s);

    s = '0; s.luHazard = 1'b1; s.memWait = 1'b1;
    applyStimulus(s);
    s = '0; s.ifWait = 1'b1;
    applyStimulus(s);

    s = '0; s.brEn = 1'b1; s.brTo = 32'h80;
    applyStimulus(s);
    s = '0;
    applyStimulus(s);

    s = '0; s.brEn = 1'b1; s.brTo = 32'h100; s.ifWait = 1'b1;
    applyStimulus(s);
    s = '0; s.ifWait = 1'b1;
    applyStimulus(s);
    applyStimulus(s);
    s = '0;
    applyStimulus(s);
    applyStimulus(s);

    s = '0; s.brEn = 1'b1; s.brTo = 32'h100; s.divBusy = 1'b1;
    applyStimulus(s);
    s = '0; s.trapEn = 1'b1; s.trapVec = 32'h200; s.divBusy = 1'b1;
    applyStimulus(s);
    s = '0; s.mretEn = 1'b1; s.mepc = 32'h300; s.divBusy = 1'b1;
    applyStimulus(s);
    s = '0;
    applyStimulus(s);
    applyStimulus(s);

    s = '0; s.ifWait = 1'b1; s.brEn = 1'b1; s.brTo = 32'h400;
    applyStimulus(s);
    s = '0; s.brEn = 1'b1; s.brTo = 32'h500;
    applyStimulus(s);

    s = '0; s.trapEn = 1'b1; s.trapVec = 32'hA0; s.mretEn = 1'b1; s.mepc = 32'hB0;
    s.brEn = 1'b1; s.brTo = 32'hC0;
    applyStimulus(s);
    s = '0;
    applyStimulus(s);

    s = '0; s.ifWait = 1'b1;
    for (int i = 0; i < HANG_LIMIT + 3; i++) applyStimulus(s);
    s = '0;
    applyStimulus(s);
    applyStimulus(s);
    s = '0; s.memWait = 1'b1; s.mretEn = 1'b1; s.mepc = 32'h600;
    applyStimulus(s);
    s = '0; s.memWait = 1'b1;
    applyStimulus(s);
    s = '0; s.rst = 1'b1;
    applyStimulus(s);
    s = '0;
    for (int i = 0; i < 4; i++) applyStimulus(s);

    for (int i = 0; i < 2000; i++) begin
      s          = '0;
      s.rst      = ($urandom_range(0, 299) == 0);
      s.ifWait   = ($urandom_range(0, 3) == 0);
      s.luHazard = ($urandom_range(0, 7) == 0);
      s.divBusy  = ($urandom_range(0, 7) == 0);
      s.memWait  = ($urandom_range(0, 7) == 0);
      s.trapEn   = ($urandom_range(0, 9) == 0);
      s.trapVec  = $urandom;
      s.mretEn   = ($urandom_range(0, 7) == 0);
      s.mepc     = $urandom;
      s.brEn     = ($urandom_range(0, 3) == 0);
      s.brTo     = $urandom;
      applyStimulus(s);
    end

    repeat (3) @(posedge clk);
    testsRun++;
    if (expQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL drain: got %0d unchecked entries, want 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/pc_sched.md
Name: pc_sched

Overview:
- Front-end scheduler for the PC register. Merges per-stage stall requests into the pipeline `hold_code` and arbitrates redirect sources (trap, mret, branch) into one `jmp_en`/`jmp_to` pair.
- A redirect that arrives while the PC is held is buffered until the PC can accept it, so no redirect is lost.
- Sits between hazard/exception logic and the PC / IF-ID registers. Also asserts the front-end flush and a sticky hang flag.

Parameters:
ADDR_W, 32, width of instruction addresses
HANG_LIMIT, 1024, consecutive PC-hold cycles before hang_err sets
CNT_W, 11, width of the hold counter; must hold HANG_LIMIT

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
if_wait  in  1  instruction memory not ready; requests HOLD_CODE_PC
lu_hazard  in  1  load-use hazard; requests HOLD_CODE_ID
div_busy  in  1  multicycle EX unit busy; requests HOLD_CODE_EX
mem_wait  in  1  data memory not ready; requests HOLD_CODE_MEM
trap_en  in  1  trap request (priority 0, highest)
trap_vec  in  ADDR_W  trap target
mret_en  in  1  exception return (priority 1)
mepc  in  ADDR_W  mret target
br_en  in  1  taken branch/jump from EX (priority 2)
br_to  in  ADDR_W  branch target
hold_code  out  3  merged hold level to all pipeline registers
jmp_en  out  1  redirect to PC this cycle
jmp_to  out  ADDR_W  redirect target
flush_fe  out  1  flush IF/ID and ID/EX
pend  out  1  a buffered redirect is waiting
hang_err  out  1  sticky: PC held >= HANG_LIMIT consecutive cycles

Behaviour:
- Reset: clk, rst named as listed; rst asynchronous, active-high.
  - While rst=1: state=IDLE, pend_addr=0, pend_pri=3 (none), hold_cnt=0, hang_err=0.
  - Outputs forced to jmp_en=0, jmp_to=0, flush_fe=0, pend=0, hold_code=HOLD_CODE_NONE.
- hold_code: combinational maximum of the levels requested by active stall inputs; HOLD_CODE_NONE if none. Ordering is NONE(0) < PC(1) < IF(2) < ID(3) < EX(4) < MEM(5).
- held = (hold_code >= HOLD_CODE_PC). This is the same compare the PC register applies.
- Arbitration: fixed priority trap > mret > br. win_en = OR of the three requests; win_addr and win_pri come from the highest-priority active request. Lower-priority requests in the same cycle are dropped.
- FSM state IDLE:
  - win_en & !held: jmp_en=1, jmp_to=win_addr, flush_fe=1 in the same cycle (zero latency, combinational). Stay in IDLE.
  - win_en & held: register win_addr/win_pri into pend_addr/pend_pri; next state PEND; jmp_en=0.
  - Otherwise: jmp_en=0, jmp_to=0, flush_fe=0.
- FSM state PEND (pend=1):
  - Incoming win with win_pri < pend_pri (strictly higher priority) overwrites pend_addr/pend_pri. Equal or lower priority is ignored.
  - !held: jmp_en=1, flush_fe=1. jmp_to is win_addr if an incoming win is strictly higher priority, otherwise pend_addr. Next state IDLE; pend_pri=3.
  - held: jmp_en=0; stay in PEND.
- flush_fe equals jmp_en in every cycle.
- Hang counter:
  - hold_cnt increments while held and saturates at HANG_LIMIT; clears on any !held cycle.
  - hang_err sets when hold_cnt reaches HANG_LIMIT and clears only on rst.
- Reset mid-PEND discards the buffered redirect; no jmp_en is issued after reset release.
- No redirect is ever accepted while held. jmp_en=1 implies held=0.

Decomposition:
- Shared package/define file:
  - HOLD_CODE_* values and 3-bit hold_code width (BUS_HOLD_CODE).
  - Redirect priority constants PRI_TRAP=0, PRI_MRET=1, PRI_BR=2, PRI_NONE=3.
  - BUS_ADDR_MEM.
- One natural sub-module: redir_arb. Combinational fixed-priority select that produces win_en/win_addr/win_pri. The FSM, pending buffer and hang counter remain in pc_sched.

Test Plan:
- Stall merge: lu_hazard=1 and mem_wait=1, no redirect -> hold_code=5, jmp_en=0. Then if_wait alone -> hold_code=1.
- Unheld redirect: br_en=1, br_to=0x80, no stalls -> jmp_en=1, jmp_to=0x80, flush_fe=1 same cycle; pend=0.
- Buffered redirect: br_en=1, br_to=0x100 while if_wait=1 for 3 cycles -> pend=1, jmp_en=0 for 3 cycles. First cycle with if_wait=0 -> jmp_en=1, jmp_to=0x100, then pend=0.
- Priority override in PEND: pending br 0x100 held, then trap_en with trap_vec=0x200 -> release gives jmp_to=0x200. A later mret during a pending trap is ignored.
- Simultaneous sources: trap_en, mret_en, br_en all 1, unheld -> jmp_to=trap_vec only; one jmp_en pulse.
- Hang and reset: if_wait=1 for HANG_LIMIT cycles -> hang_err=1, stays 1 after if_wait drops. Assert rst during PEND -> hang_err=0, pend=0, and no jmp_en after release.
